// File: rtl/uart_char_writer.sv
// rtl/uart_char_writer.sv - UART transmitter with a small character FIFO
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   char        character to transmit
//   char_valid  char is valid this cycle
//   char_ready  FIFO can accept a character this cycle (from registered count)
//   UART_TX     serial line, idles high, driven straight from a flop
//   busy        registered: FSM not idle, or characters still buffered
//   fifo_count  characters currently buffered
module uart_char_writer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    char,
  input  logic                          char_valid,
  output logic                          char_ready,
  output logic                          UART_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int BCNT_W   = $clog2(CLKS_PER_BIT * 2) + 1;
  localparam int BIT_END  = CLKS_PER_BIT - 1;
  localparam int STOP_END = STOP_BITS * CLKS_PER_BIT - 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_q, count_n;
  logic [BCNT_W-1:0]   cyc_cnt, cyc_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [7:0]          shift, shift_n;
  logic                tx_q, tx_n;
  logic                busy_q, busy_n;
  logic                push, pop;
  logic                bit_done, stop_done;

  assign char_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = char_valid && char_ready;
  assign UART_TX    = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  assign bit_done  = (cyc_cnt == BCNT_W'(BIT_END));
  assign stop_done = (cyc_cnt == BCNT_W'(STOP_END));

  always_comb begin
    state_n   = state;
    tx_n      = tx_q;
    cyc_n     = cyc_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n      = 1'b1;
        cyc_n     = '0;
        bit_idx_n = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          // Shift register holds the not-yet-sent bits; bit 0 goes out next.
          tx_n      = shift[0];
          shift_n   = shift >> 1;
          bit_idx_n = '0;
          cyc_n     = '0;
          state_n   = DATA;
        end else begin
          cyc_n = cyc_cnt + BCNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cyc_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n      = shift[0];
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cyc_n = cyc_cnt + BCNT_W'(1);
        end
      end
      STOP: begin
        if (stop_done) begin
          cyc_n = '0;
          // Chain straight into the next start bit so queued frames have no gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cyc_n = cyc_cnt + BCNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase

    busy_n = (state_n != IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cyc_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      count_q <= count_n;
      cyc_cnt <= cyc_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char;
  end

endmodule

// File: tb/tb_uart_char_writer.sv
// tb/tb_uart_char_writer.sv - self-checking bench for uart_char_writer
module tb_uart_char_writer;

  logic       clk;
  logic       rst1_n, v1, rdy1, tx1, busy1;
  logic [7:0] ch1;
  logic [2:0] cnt1;
  logic       rst4_n, v4, rdy4, tx4, busy4;
  logic [7:0] ch4;
  logic [2:0] cnt4;

  int n_checks;
  int n_pass;

  bit         log_en;
  bit         tx1_log[$];
  bit         busy1_log[$];
  bit         tx4_log[$];
  bit         busy4_log[$];
  bit         exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_frame_err;

  uart_char_writer #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .char(ch1), .char_valid(v1), .char_ready(rdy1),
    .UART_TX(tx1), .busy(busy1), .fifo_count(cnt1)
  );

  uart_char_writer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut4 (
    .clk(clk), .rst_n(rst4_n), .char(ch4), .char_valid(v4), .char_ready(rdy4),
    .UART_TX(tx4), .busy(busy4), .fifo_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record line state shortly after every edge; index k = value after edge k of the window.
  always @(posedge clk) begin
    #2;
    if (log_en) begin
      tx1_log.push_back(tx1);
      busy1_log.push_back(busy1);
      tx4_log.push_back(tx4);
      busy4_log.push_back(busy4);
    end
  end

  task automatic start_log();
    tx1_log.delete(); busy1_log.delete(); tx4_log.delete(); busy4_log.delete();
    log_en = 1'b1;
  endtask

  // Reference waveform of one frame: start, 8 data bits LSB first, stop bits.
  function automatic void add_frame(input logic [7:0] c, input int cpb, input int sb);
    repeat (cpb) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) repeat (cpb) exp_q.push_back(c[b]);
    repeat (sb * cpb) exp_q.push_back(1'b1);
  endfunction

  // Behavioural one-sample-per-bit receiver over the recorded line.
  function automatic void decode1();
    int i;
    logic [7:0] c;
    i = 0;
    rx_q.delete();
    rx_frame_err = 0;
    while (i + 9 < tx1_log.size()) begin
      if (tx1_log[i] == 1'b0) begin
        for (int b = 0; b < 8; b++) c[b] = tx1_log[i + 1 + b];
        if (tx1_log[i + 9] != 1'b1) rx_frame_err++;
        rx_q.push_back(c);
        i += 10;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic test_reset();
    rst1_n = 1'b0; rst4_n = 1'b0;
    v1 = 1'b1; ch1 = 8'h77; v4 = 1'b1; ch4 = 8'h66;
    repeat (3) @(negedge clk);
    n_checks++; if (tx1 !== 1'b1) $display("FAIL reset_tx1 got %b exp 1", tx1); else n_pass++;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b exp 0", busy1); else n_pass++;
    n_checks++; if (cnt1 !== 3'd0) $display("FAIL reset_count1 got %0d exp 0", cnt1); else n_pass++;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL reset_ready1 got %b exp 1", rdy1); else n_pass++;
    n_checks++; if (tx4 !== 1'b1) $display("FAIL reset_tx4 got %b exp 1", tx4); else n_pass++;
    n_checks++; if (cnt4 !== 3'd0) $display("FAIL reset_count4 got %0d exp 0", cnt4); else n_pass++;
    rst1_n = 1'b1; rst4_n = 1'b1; v1 = 1'b0; v4 = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt1 !== 3'd0) $display("FAIL reset_no_push got %0d exp 0", cnt1); else n_pass++;
    n_checks++; if (tx1 !== 1'b1) $display("FAIL reset_idle_tx got %b exp 1", tx1); else n_pass++;
  endtask

  task automatic test_single();
    int bad;
    start_log();
    ch1 = 8'hA5; v1 = 1'b1;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL single_ready got %b exp 1", rdy1); else n_pass++;
    @(negedge clk);
    v1 = 1'b0;
    repeat (13) @(negedge clk);
    log_en = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b1);
    add_frame(8'hA5, 1, 1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= tx1_log.size() || tx1_log[i] != exp_q[i])) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL single_wave first bad sample %0d got %b exp %b", bad,
                           (bad < tx1_log.size()) ? tx1_log[bad] : 1'bx, exp_q[bad]);
    else n_pass++;
    n_checks++; if (busy1_log[10] !== 1'b1) $display("FAIL single_busy_stop got %b exp 1", busy1_log[10]); else n_pass++;
    n_checks++; if (busy1_log[11] !== 1'b0) $display("FAIL single_busy_end got %b exp 0", busy1_log[11]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] list[$];
    int idx, max_cnt, s, bad;
    bit saw_full;
    list = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    idx = 0; max_cnt = 0; saw_full = 1'b0;
    start_log();
    for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
      v1 = 1'b1; ch1 = list[idx];
      if (rdy1 === 1'b1) begin
        idx++;
      end else begin
        saw_full = 1'b1;
        n_checks++; if (cnt1 !== 3'd4) $display("FAIL b2b_not_ready_count got %0d exp 4", cnt1); else n_pass++;
      end
      @(negedge clk);
      if (int'(cnt1) > max_cnt) max_cnt = int'(cnt1);
    end
    v1 = 1'b0;
    for (int k = 0; k < 150 && busy1 !== 1'b0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    log_en = 1'b0;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL b2b_idle_timeout busy got %b exp 0", busy1); else n_pass++;
    n_checks++; if (idx != 6) $display("FAIL b2b_accepted got %0d exp 6", idx); else n_pass++;
    n_checks++; if (saw_full !== 1'b1) $display("FAIL b2b_backpressure got %b exp 1", saw_full); else n_pass++;
    n_checks++; if (max_cnt != 4) $display("FAIL b2b_max_count got %0d exp 4", max_cnt); else n_pass++;
    s = -1;
    for (int i = 0; i < tx1_log.size(); i++) if (s < 0 && tx1_log[i] == 1'b0) s = i;
    n_checks++; if (s != 1) $display("FAIL b2b_latency got %0d exp 1", s); else n_pass++;
    exp_q.delete();
    foreach (list[i]) add_frame(list[i], 1, 1);
    exp_q.push_back(1'b1);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (s < 0 || s + i >= tx1_log.size() || tx1_log[s + i] != exp_q[i])) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL b2b_contiguous_wave first bad sample %0d exp %b", bad, exp_q[bad]); else n_pass++;
    decode1();
    n_checks++; if (rx_q.size() != 6) $display("FAIL b2b_rx_count got %0d exp 6", rx_q.size()); else n_pass++;
  endtask

  task automatic test_bit_timing();
    int s, bad;
    start_log();
    ch4 = 8'h3C; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    for (int k = 0; k < 100 && busy4 !== 1'b0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    log_en = 1'b0;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL timing_idle_timeout busy got %b exp 0", busy4); else n_pass++;
    s = -1;
    for (int i = 0; i < tx4_log.size(); i++) if (s < 0 && tx4_log[i] == 1'b0) s = i;
    n_checks++; if (s != 1) $display("FAIL timing_latency got %0d exp 1", s); else n_pass++;
    exp_q.delete();
    add_frame(8'h3C, 4, 2);
    exp_q.push_back(1'b1);
    n_checks++; if (exp_q.size() != 45) $display("FAIL timing_model_len got %0d exp 45", exp_q.size()); else n_pass++;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (s < 0 || s + i >= tx4_log.size() || tx4_log[s + i] != exp_q[i])) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL timing_wave first bad sample %0d exp %b", bad, exp_q[bad]); else n_pass++;
    n_checks++; if (busy4_log.size() < 46 || busy4_log[44] !== 1'b1)
      $display("FAIL timing_busy_last_stop got %b exp 1", (busy4_log.size() > 44) ? busy4_log[44] : 1'bx); else n_pass++;
    n_checks++; if (busy4_log.size() < 46 || busy4_log[45] !== 1'b0)
      $display("FAIL timing_busy_after_frame got %b exp 0", (busy4_log.size() > 45) ? busy4_log[45] : 1'bx); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int highs;
    ch1 = 8'hFF; v1 = 1'b1;
    @(negedge clk); ch1 = 8'h11;
    @(negedge clk); ch1 = 8'h22;
    @(negedge clk); v1 = 1'b0;
    n_checks++; if (cnt1 !== 3'd2) $display("FAIL mid_queued got %0d exp 2", cnt1); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (tx1 !== 1'b1) $display("FAIL mid_bit3 got %b exp 1", tx1); else n_pass++;
    rst1_n = 1'b0;
    @(negedge clk);
    n_checks++; if (tx1 !== 1'b1) $display("FAIL mid_reset_tx got %b exp 1", tx1); else n_pass++;
    n_checks++; if (cnt1 !== 3'd0) $display("FAIL mid_reset_count got %0d exp 0", cnt1); else n_pass++;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL mid_reset_busy got %b exp 0", busy1); else n_pass++;
    rst1_n = 1'b1;
    start_log();
    repeat (30) @(negedge clk);
    log_en = 1'b0;
    highs = 0;
    foreach (tx1_log[i]) if (tx1_log[i] == 1'b1) highs++;
    n_checks++; if (highs != 30) $display("FAIL mid_no_frames high samples got %0d exp 30", highs); else n_pass++;
    n_checks++; if (cnt1 !== 3'd0) $display("FAIL mid_after_count got %0d exp 0", cnt1); else n_pass++;
  endtask

  task automatic test_loopback();
    logic [7:0] list[$];
    int gap;
    list = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    for (int i = 0; i < 8; i++) list.push_back(8'($urandom));
    start_log();
    foreach (list[i]) begin
      gap = $urandom_range(0, 3);
      v1 = 1'b0;
      repeat (gap) @(negedge clk);
      ch1 = list[i]; v1 = 1'b1;
      for (int k = 0; k < 40 && rdy1 !== 1'b1; k++) @(negedge clk);
      @(negedge clk);
    end
    v1 = 1'b0;
    for (int k = 0; k < 200 && busy1 !== 1'b0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    log_en = 1'b0;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL loop_idle_timeout busy got %b exp 0", busy1); else n_pass++;
    decode1();
    n_checks++; if (rx_q.size() != list.size()) $display("FAIL loop_rx_count got %0d exp %0d", rx_q.size(), list.size()); else n_pass++;
    n_checks++; if (rx_frame_err != 0) $display("FAIL loop_stop_bits got %0d bad stops exp 0", rx_frame_err); else n_pass++;
    foreach (list[i]) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== list[i])
        $display("FAIL loop_char%0d got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, list[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; log_en = 1'b0;
    rst1_n = 1'b0; rst4_n = 1'b0; v1 = 1'b0; v4 = 1'b0; ch1 = 8'h00; ch4 = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_bit_timing();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
